// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag controller for an asynchronous FIFO.
// Produces the binary write address and a Gray pointer, and derives full, level, almost-full and overflow from the synchronized read pointer.
module fifo_wptr_full #(
    parameter int ADDR_WIDTH         = 4,
    parameter int ALMOST_FULL_THRESH = 2**ADDR_WIDTH - 2
) (
    input  logic                  w_clk_in,
    input  logic                  w_rst_in,
    input  logic                  w_request_in,
    input  logic [ADDR_WIDTH:0]   r_gray_ptr_in,
    output logic [ADDR_WIDTH-1:0] w_addr_out,
    output logic                  w_full_out,
    output logic [ADDR_WIDTH:0]   w_gray_ptr_out,
    output logic                  w_almost_full_out,
    output logic [ADDR_WIDTH:0]   w_level_out,
    output logic                  w_overflow_out
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_THRESH);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wbin_q,  wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] rq1_q,   rq1_d;
    logic [PW-1:0] rq2_q,   rq2_d;
    logic [PW-1:0] level_q, level_d;
    logic          full_q,  full_d;
    logic          afull_q, afull_d;
    logic          ovf_q,   ovf_d;
    logic          w_en;
    logic [PW-1:0] rbin_s;

    always_comb begin
        // Same enable as the memory, so pointer and stored data never disagree.
        w_en    = w_request_in & ~full_q;
        wbin_d  = wbin_q + PW'(w_en);
        wgray_d = bin2gray(wbin_d);

        rq1_d   = r_gray_ptr_in;
        rq2_d   = rq1_q;
        rbin_s  = gray2bin(rq2_q);

        // Full and level use the post-write pointer against the stale read pointer,
        // so they can only be pessimistic, never early.
        full_d  = (wgray_d == {~rq2_q[ADDR_WIDTH:ADDR_WIDTH-1], rq2_q[ADDR_WIDTH-2:0]});
        level_d = wbin_d - rbin_s;
        afull_d = (level_d >= AF_TH);
        ovf_d   = ovf_q | (w_request_in & full_q);
    end

    always_ff @(posedge w_clk_in or posedge w_rst_in) begin
        if (w_rst_in) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            rq1_q   <= '0;
            rq2_q   <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            rq1_q   <= rq1_d;
            rq2_q   <= rq2_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign w_addr_out        = wbin_q[ADDR_WIDTH-1:0];
    assign w_gray_ptr_out    = wgray_q;
    assign w_full_out        = full_q;
    assign w_level_out       = level_q;
    assign w_almost_full_out = afull_q;
    assign w_overflow_out    = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full with ADDR_WIDTH=3, ALMOST_FULL_THRESH=6.
module tb_fifo_wptr_full;

    logic       w_clk_in;
    logic       w_rst_in;
    logic       w_request_in;
    logic [3:0] r_gray_ptr_in;
    logic [2:0] w_addr_out;
    logic       w_full_out;
    logic [3:0] w_gray_ptr_out;
    logic       w_almost_full_out;
    logic [3:0] w_level_out;
    logic       w_overflow_out;

    int errors = 0;
    int checks = 0;

    fifo_wptr_full #(
        .ADDR_WIDTH(3),
        .ALMOST_FULL_THRESH(6)
    ) dut (
        .w_clk_in(w_clk_in),
        .w_rst_in(w_rst_in),
        .w_request_in(w_request_in),
        .r_gray_ptr_in(r_gray_ptr_in),
        .w_addr_out(w_addr_out),
        .w_full_out(w_full_out),
        .w_gray_ptr_out(w_gray_ptr_out),
        .w_almost_full_out(w_almost_full_out),
        .w_level_out(w_level_out),
        .w_overflow_out(w_overflow_out)
    );

    initial w_clk_in = 1'b0;
    always #5 w_clk_in = ~w_clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk_in);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},  32'(w_addr_out), 0);
        chk({tag, "_gray"},  32'(w_gray_ptr_out), 0);
        chk({tag, "_full"},  32'(w_full_out), 0);
        chk({tag, "_level"}, 32'(w_level_out), 0);
        chk({tag, "_afull"}, 32'(w_almost_full_out), 0);
        chk({tag, "_ovf"},   32'(w_overflow_out), 0);
    endtask

    logic [3:0] gseq [0:8] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
    logic [3:0] prev_gray;

    initial begin
        w_rst_in      = 1'b1;
        w_request_in  = 1'b0;
        r_gray_ptr_in = 4'd0;
        tick();
        tick();
        chk_all_zero("rst");
        w_rst_in = 1'b0;

        // 1: fill from empty
        chk("t1_addr0", 32'(w_addr_out), 0);
        w_request_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("t1_addr%0d", k),  32'(w_addr_out), 32'(k % 8));
            chk($sformatf("t1_gray%0d", k),  32'(w_gray_ptr_out), 32'(gseq[k]));
            chk($sformatf("t1_level%0d", k), 32'(w_level_out), 32'(k));
            chk($sformatf("t1_full%0d", k),  32'(w_full_out), (k == 8) ? 1 : 0);
            chk($sformatf("t1_afull%0d", k), 32'(w_almost_full_out), (k >= 6) ? 1 : 0);
        end
        chk("t1_ovf", 32'(w_overflow_out), 0);

        // 2: requests while full
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("t2_addr", 32'(w_addr_out), 0);
            chk("t2_gray", 32'(w_gray_ptr_out), 12);
            chk("t2_ovf",  32'(w_overflow_out), 1);
        end
        w_request_in = 1'b0;
        tick();
        chk("t2_ovf_sticky", 32'(w_overflow_out), 1);
        chk("t2_full", 32'(w_full_out), 1);

        // 3: read pointer advances to bin 1
        r_gray_ptr_in = 4'b0001;
        tick();
        chk("t3_full_e1", 32'(w_full_out), 1);
        tick();
        chk("t3_full_e2", 32'(w_full_out), 1);
        tick();
        chk("t3_full_e3", 32'(w_full_out), 0);
        chk("t3_level",   32'(w_level_out), 7);
        chk("t3_afull",   32'(w_almost_full_out), 1);

        // 4: wrap, read pointer at bin 8
        r_gray_ptr_in = 4'b1100;
        tick();
        tick();
        tick();
        chk("t4_level0", 32'(w_level_out), 0);
        chk("t4_full0",  32'(w_full_out), 0);
        w_request_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            prev_gray = w_gray_ptr_out;
            tick();
            chk($sformatf("t4_onebit%0d", k), 32'($countones(prev_gray ^ w_gray_ptr_out)), 1);
            chk($sformatf("t4_addr%0d", k),   32'(w_addr_out), 32'(k % 8));
            chk($sformatf("t4_full%0d", k),   32'(w_full_out), (k == 8) ? 1 : 0);
        end
        w_request_in = 1'b0;
        chk("t4_gray_wrap", 32'(w_gray_ptr_out), 0);
        chk("t4_level8",    32'(w_level_out), 8);

        // 5: simultaneous write and read advance; read moves to bin 11 (level 5)
        r_gray_ptr_in = 4'b1110;
        tick();
        tick();
        tick();
        chk("t5_level5", 32'(w_level_out), 5);
        chk("t5_afull0", 32'(w_almost_full_out), 0);
        chk("t5_full0",  32'(w_full_out), 0);
        w_request_in  = 1'b1;
        r_gray_ptr_in = 4'b1010;
        tick();
        w_request_in  = 1'b0;
        chk("t5_level_w",  32'(w_level_out), 6);
        chk("t5_afull_w",  32'(w_almost_full_out), 1);
        tick();
        chk("t5_level_e2", 32'(w_level_out), 6);
        tick();
        chk("t5_level_e3", 32'(w_level_out), 5);
        chk("t5_afull_e3", 32'(w_almost_full_out), 0);

        // 6: async reset mid-burst
        w_request_in = 1'b1;
        tick();
        tick();
        chk("t6_addr_pre", 32'(w_addr_out), 3);
        #2;
        w_rst_in = 1'b1;
        #1;
        chk_all_zero("t6_rst");
        w_request_in  = 1'b0;
        r_gray_ptr_in = 4'd0;
        tick();
        w_rst_in = 1'b0;
        chk("t6_addr_rel", 32'(w_addr_out), 0);
        w_request_in = 1'b1;
        tick();
        w_request_in = 1'b0;
        chk("t6_addr_post", 32'(w_addr_out), 1);
        chk("t6_gray_post", 32'(w_gray_ptr_out), 1);
        chk("t6_level_post", 32'(w_level_out), 1);
        chk("t6_ovf_post",  32'(w_overflow_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-side pointer and full-flag controller for the asynchronous FIFO; sits directly upstream of fifo_mem in the write clock domain.
- Generates the binary write address and the full flag that fifo_mem consumes.
- Exports a Gray-coded write pointer for the read domain.
- Synchronizes the read domain's Gray pointer into the write domain; derives fill level, almost-full and a sticky overflow flag.

Parameters:
- ADDR_WIDTH, 4, memory address width; depth = 2**ADDR_WIDTH; must be >= 2.
- ALMOST_FULL_THRESH, 2**ADDR_WIDTH - 2, fill level at or above which w_almost_full_out asserts; range 1..2**ADDR_WIDTH.

Ports:
- w_clk_in  input  1  write-domain clock; all state updates on its rising edge.
- w_rst_in  input  1  asynchronous, active-high reset.
- w_request_in  input  1  write request from producer; same signal drives fifo_mem.
- r_gray_ptr_in  input  ADDR_WIDTH+1  read pointer, Gray code, from read domain (asynchronous to w_clk_in).
- w_addr_out  output  ADDR_WIDTH  write address to fifo_mem.
- w_full_out  output  1  FIFO full, to fifo_mem and producer.
- w_gray_ptr_out  output  ADDR_WIDTH+1  registered Gray write pointer, to read-domain synchronizer.
- w_almost_full_out  output  1  level >= ALMOST_FULL_THRESH.
- w_level_out  output  ADDR_WIDTH+1  conservative fill level, 0..2**ADDR_WIDTH.
- w_overflow_out  output  1  sticky: write requested while full.

Behaviour:
- Reset (async assert, sync release): all flops 0.
  - Internal binary pointer wbin (ADDR_WIDTH+1 bits): 0.
  - Synchronizer stages rq1, rq2: 0.
  - All outputs: 0.
  - Outputs go to 0 immediately on assert, without waiting for a clock edge.
- Write enable: w_en = w_request_in & ~w_full_out.
  - This is identical to fifo_mem's internal enable, so pointer and memory always agree.
- Pointer update:
  - wbin_next = wbin + w_en, modulo 2**(ADDR_WIDTH+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
  - Both are registered.
  - w_addr_out = wbin[ADDR_WIDTH-1:0], combinational from the flop.
  - w_gray_ptr_out is driven directly from the Gray flop, with no combinational logic after it.
- Read-pointer synchronizer:
  - 2-flop chain: rq1 <= r_gray_ptr_in; rq2 <= rq1.
  - Nothing else samples r_gray_ptr_in.
- Full, registered:
  - w_full_out <= (wgray_next == {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]}).
  - A write that fills the last slot asserts full on that same edge.
- Level, registered:
  - rbin_s = Gray-to-binary of rq2.
  - w_level_out <= wbin_next - rbin_s, modulo 2**(ADDR_WIDTH+1).
  - Invariant: w_full_out == (w_level_out == 2**ADDR_WIDTH).
  - Invariant: w_level_out never exceeds 2**ADDR_WIDTH.
- Almost-full, registered: w_almost_full_out <= (level_next >= ALMOST_FULL_THRESH).
- Latency:
  - A read-pointer change is reflected in full, level and almost_full 3 rising edges after it is stable at r_gray_ptr_in (2 sync stages + 1 output register).
  - A write is reflected in all outputs on the write's own edge.
- Full and pessimism:
  - While full, requests are ignored and the pointer holds.
  - Full may remain asserted late (pessimistic) and must never deassert early.
- Overflow:
  - w_overflow_out <= w_overflow_out | (w_request_in & w_full_out).
  - Cleared only by reset.
- Wrap-around:
  - wbin wraps from 2**(ADDR_WIDTH+1)-1 to 0.
  - The extra MSB distinguishes full from empty.
  - Exactly one bit of w_gray_ptr_out changes per accepted write, including at wrap.
- Simultaneous events:
  - A write and a read-pointer advance in the same cycle are both accounted for: level = prior + 1 - (sync'd advance).
  - Full evaluates on the post-write pointer.

Test Plan (ADDR_WIDTH=3, ALMOST_FULL_THRESH=6):
1. Reset, r_gray_ptr_in=0, 8 consecutive requests.
   - Expect w_addr_out 0..7.
   - Expect w_gray_ptr_out sequence 0,1,3,2,6,7,5,4,12.
   - Expect w_full_out=1 and w_level_out=8 on the 8th write's edge.
   - Expect w_almost_full_out=1 from the 6th write's edge onward.
2. From full, hold w_request_in=1 for 2 cycles.
   - Expect w_addr_out to stay 0 and w_gray_ptr_out to stay 12.
   - Expect w_overflow_out=1, and still 1 after w_request_in drops.
3. From full, drive r_gray_ptr_in=4'b0001 (read bin 1).
   - Expect w_full_out to stay 1 for 2 edges, then drop on the 3rd edge.
   - Expect w_level_out=7.
4. Wrap: read at bin 8 (r_gray_ptr_in=4'b1100), writes advance wbin 8..15 then to 0.
   - Expect full asserted when wbin=0 (Gray 0000 vs {~11,00}).
   - Every accepted write changes exactly one Gray bit.
5. Simultaneous: level=5, issue one write in the same cycle r_gray_ptr_in advances by one.
   - Expect level 6 on the write edge.
   - Expect level 5 two edges later.
   - Expect almost_full to toggle 1 then 0 accordingly.
6. Assert w_rst_in between clock edges mid-burst.
   - Expect all outputs 0 immediately.
   - Expect w_overflow_out cleared.
   - After release, the next write goes to w_addr_out=0.
